// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 bus receiver.
// Provides the mode state encoding, the function-set decode constants,
// the FIFO entry layout ({from8, rs, byte}) and a function-set decode helper.
package hd44780_pkg;

    typedef enum logic [1:0] {
        M8    = 2'd0,
        M4_HI = 2'd1,
        M4_LO = 2'd2
    } rx_state_t;

    // Nybble that switches an 8-bit-mode receiver into 4-bit mode.
    localparam logic [3:0] FS_4BIT_NYB = 4'h2;
    // Function set with DL=1 (upper bits 0011) returns the bus to 8-bit mode.
    localparam logic [7:0] FS_DL_MASK  = 8'hF0;
    localparam logic [7:0] FS_DL8      = 8'h30;

    localparam int ENTRY_W = 10;

    typedef struct packed {
        logic       from8;
        logic       rs;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic is_fs_dl8(input logic [7:0] b);
        return (b & FS_DL_MASK) == FS_DL8;
    endfunction

endpackage

// File: rtl/hd44780_rx_fifo.sv
// Synchronous FIFO with registered head outputs.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write request and entry
//   push_ok           write accepted this cycle (not full, or full with pop)
//   pop               consume head entry (ignored when empty)
//   rd_valid, rd_data registered head-of-queue view; a written entry shows up
//                     one cycle after the write, the next entry one cycle after a pop
module hd44780_rx_fifo
    import hd44780_pkg::*;
#(
    parameter int AW = 3,
    parameter int W  = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         push_ok,
    input  logic         pop,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          do_pop_s;
    logic          do_push_s;
    logic [AW-1:0] rd_ptr_next_s;
    logic [AW:0]   remain_s;

    assign full_s        = (count_r == (AW+1)'(DEPTH));
    assign empty_s       = (count_r == '0);
    assign do_pop_s      = pop & ~empty_s;
    // A pop in the same cycle frees the slot for a write into a full FIFO.
    assign do_push_s     = push & (~full_s | do_pop_s);
    assign push_ok       = do_push_s;
    assign rd_ptr_next_s = rd_ptr_r + AW'(do_pop_s);
    // Entries left after this cycle's pop, excluding this cycle's write,
    // so a fresh write becomes visible one cycle later than the write edge.
    assign remain_s      = count_r - (AW+1)'(do_pop_s);

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered head view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(do_push_s);
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
            rd_valid <= (remain_s != '0);
            rd_data  <= mem[rd_ptr_next_s];
        end
    end

endmodule

// File: rtl/hd44780_bus_receiver.sv
// Receiving end of the HD44780 4-bit LCD bus.
// Samples E/RS/D7..D4, qualifies E strobes by minimum high time, tracks the
// 8-bit/4-bit interface width and queues reassembled bytes in a FIFO.
// Ports:
//   CLK_I, RST_I                  clock, asynchronous active-high reset
//   i_e, i_rs, i_nybble           LCD bus pins
//   i_ready                       consumer pops head entry when o_valid
//   i_clear_err                   clears sticky error flags
//   o_valid/o_byte/o_rs/o_from8   head FIFO entry
//   o_mode4, o_pending            interface width, high nybble held
//   o_count                       bytes accepted into the FIFO (wrapping)
//   o_err_short/o_err_rs/o_err_ovf sticky errors
module hd44780_bus_receiver
    import hd44780_pkg::*;
#(
    parameter int FIFO_AW    = 3,
    parameter int E_MIN_HIGH = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        i_e,
    input  logic        i_rs,
    input  logic [3:0]  i_nybble,
    input  logic        i_ready,
    input  logic        i_clear_err,
    output logic        o_valid,
    output logic [7:0]  o_byte,
    output logic        o_rs,
    output logic        o_from8,
    output logic        o_mode4,
    output logic        o_pending,
    output logic [15:0] o_count,
    output logic        o_err_short,
    output logic        o_err_rs,
    output logic        o_err_ovf
);

    localparam int CW = $clog2(E_MIN_HIGH + 1);

    logic          e_q_r;
    logic          e_d_r;
    logic          rs_q_r;
    logic [3:0]    nyb_q_r;
    logic [CW-1:0] hi_cnt_r;
    logic          rs_h_r;
    logic [3:0]    nyb_h_r;
    logic          fall_s;
    logic          long_enough_s;
    logic          strobe_s;
    logic          short_s;

    rx_state_t     state_r;
    rx_state_t     state_s;
    logic [3:0]    hi_nyb_r;
    logic [3:0]    hi_nyb_s;
    logic          hi_rs_r;
    logic          hi_rs_s;
    logic          push_s;
    rx_entry_t     push_entry_s;
    logic          rs_mis_s;
    logic          push_ok_s;
    logic          pop_s;
    rx_entry_t     head_s;
    logic [15:0]   count_r;
    logic          mode4_r;
    logic          pending_r;
    logic          err_short_r;
    logic          err_rs_r;
    logic          err_ovf_r;

    // Input register stage: pin capture, E high-time counter, held RS/data.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            e_q_r    <= 1'b0;
            e_d_r    <= 1'b0;
            rs_q_r   <= 1'b0;
            nyb_q_r  <= 4'h0;
            hi_cnt_r <= '0;
            rs_h_r   <= 1'b0;
            nyb_h_r  <= 4'h0;
        end else begin
            e_q_r   <= i_e;
            e_d_r   <= e_q_r;
            rs_q_r  <= i_rs;
            nyb_q_r <= i_nybble;
            if (e_q_r) begin
                if (hi_cnt_r < CW'(E_MIN_HIGH)) begin
                    hi_cnt_r <= hi_cnt_r + CW'(1);
                end else begin
                    hi_cnt_r <= hi_cnt_r;
                end
                rs_h_r  <= rs_q_r;
                nyb_h_r <= nyb_q_r;
            end else begin
                hi_cnt_r <= '0;
            end
        end
    end

    // Falling edge of the registered E; hi_cnt still reflects the ended pulse.
    assign fall_s        = e_d_r & ~e_q_r;
    assign long_enough_s = (hi_cnt_r >= CW'(E_MIN_HIGH));
    assign strobe_s      = fall_s & long_enough_s;
    assign short_s       = fall_s & ~long_enough_s;

    // Interface-width FSM: next state, nybble pairing and FIFO push request.
    always_comb begin
        state_s      = state_r;
        hi_nyb_s     = hi_nyb_r;
        hi_rs_s      = hi_rs_r;
        push_s       = 1'b0;
        push_entry_s = '0;
        rs_mis_s     = 1'b0;
        if (strobe_s) begin
            case (state_r)
                M8: begin
                    push_s       = 1'b1;
                    push_entry_s = '{from8: 1'b1, rs: rs_h_r, data: {nyb_h_r, 4'h0}};
                    if (!rs_h_r && (nyb_h_r == FS_4BIT_NYB)) begin
                        state_s = M4_HI;
                    end else begin
                        state_s = M8;
                    end
                end
                M4_HI: begin
                    hi_nyb_s = nyb_h_r;
                    hi_rs_s  = rs_h_r;
                    state_s  = M4_LO;
                end
                M4_LO: begin
                    // The pair takes the RS of its high half even on mismatch.
                    push_s       = 1'b1;
                    push_entry_s = '{from8: 1'b0, rs: hi_rs_r, data: {hi_nyb_r, nyb_h_r}};
                    rs_mis_s     = (rs_h_r != hi_rs_r);
                    if (!hi_rs_r && is_fs_dl8({hi_nyb_r, nyb_h_r})) begin
                        state_s = M8;
                    end else begin
                        state_s = M4_HI;
                    end
                end
                default: begin
                    state_s = M8;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, held high nybble and registered mode/pending flags.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_r   <= M8;
            hi_nyb_r  <= 4'h0;
            hi_rs_r   <= 1'b0;
            mode4_r   <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            hi_nyb_r  <= hi_nyb_s;
            hi_rs_r   <= hi_rs_s;
            mode4_r   <= (state_s != M8);
            pending_r <= (state_s == M4_LO);
        end
    end

    assign pop_s = o_valid & i_ready;

    hd44780_rx_fifo #(
        .AW (FIFO_AW),
        .W  (ENTRY_W)
    ) u_fifo (
        .clk       (CLK_I),
        .rst       (RST_I),
        .push      (push_s),
        .push_data (push_entry_s),
        .push_ok   (push_ok_s),
        .pop       (pop_s),
        .rd_valid  (o_valid),
        .rd_data   (head_s)
    );

    // Accepted-byte counter and sticky errors; a new error beats a clear.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            count_r     <= 16'd0;
            err_short_r <= 1'b0;
            err_rs_r    <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
            err_short_r <= short_s | (err_short_r & ~i_clear_err);
            err_rs_r    <= rs_mis_s | (err_rs_r & ~i_clear_err);
            err_ovf_r   <= (push_s & ~push_ok_s) | (err_ovf_r & ~i_clear_err);
        end
    end

    assign o_byte      = head_s.data;
    assign o_rs        = head_s.rs;
    assign o_from8     = head_s.from8;
    assign o_mode4     = mode4_r;
    assign o_pending   = pending_r;
    assign o_count     = count_r;
    assign o_err_short = err_short_r;
    assign o_err_rs    = err_rs_r;
    assign o_err_ovf   = err_ovf_r;

endmodule
